// File: rtl/run_detect_multi_if.sv
// rtl/run_detect_multi_if.sv - data/clear inputs and match outputs of the run detector
interface run_detect_multi_if #(
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 16
);
   logic [CHANNELS-1:0]       in_i;
   logic                      clear_i;
   logic [CHANNELS-1:0]       match_o;
   logic [CHANNELS-1:0]       match_pulse_o;
   logic [CHANNELS*CNT_W-1:0] match_count_o;
   logic                      any_match_o;

   modport master (
      output in_i, clear_i,
      input  match_o, match_pulse_o, match_count_o, any_match_o
   );

   modport slave (
      input  in_i, clear_i,
      output match_o, match_pulse_o, match_count_o, any_match_o
   );
endinterface

// File: rtl/run_detect_multi.sv
// rtl/run_detect_multi.sv - per-channel detector of RUN_LEN consecutive 1s with
// sticky/level match, one-cycle event pulse and saturating event counters
module run_detect_multi #(
   parameter int CHANNELS = 4,
   parameter int RUN_LEN  = 3,
   parameter int CNT_W    = 16,
   parameter int STICKY   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   run_detect_multi_if.slave     bus
);
   localparam int RW = (RUN_LEN < 1) ? 1 : $clog2(RUN_LEN + 1);
   localparam logic [RW-1:0] RUN_MAX = RW'(RUN_LEN);

   typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

   state_t                    state_q [CHANNELS];
   state_t                    state_d [CHANNELS];
   logic [RW-1:0]             run_q   [CHANNELS];
   logic [RW-1:0]             run_d   [CHANNELS];
   logic [CHANNELS-1:0]       det;
   logic [CHANNELS-1:0]       match_q, match_d;
   logic [CHANNELS-1:0]       pulse_q, pulse_d;
   logic [CHANNELS*CNT_W-1:0] cnt_q, cnt_d;
   logic                      any_q, any_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= IDLE;
            run_q[i]   <= '0;
         end
         match_q <= '0;
         pulse_q <= '0;
         cnt_q   <= '0;
         any_q   <= 1'b0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= state_d[i];
            run_q[i]   <= run_d[i];
         end
         match_q <= match_d;
         pulse_q <= pulse_d;
         cnt_q   <= cnt_d;
         any_q   <= any_d;
      end
   end

   always_comb begin
      logic [CNT_W-1:0] cnt_cur;
      det     = '0;
      match_d = '0;
      pulse_d = '0;
      cnt_d   = '0;
      cnt_cur = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         state_d[i] = state_q[i];
         run_d[i]   = run_q[i];
         case (state_q[i])
            IDLE: begin
               if (bus.in_i[i]) begin
                  run_d[i] = RW'(1);
                  if (RUN_LEN == 1) begin
                     state_d[i] = DONE;
                     det[i]     = 1'b1;
                  end else begin
                     state_d[i] = COUNT;
                  end
               end
            end
            COUNT: begin
               if (bus.in_i[i]) begin
                  run_d[i] = run_q[i] + RW'(1);
                  if (run_q[i] + RW'(1) == RUN_MAX) begin
                     state_d[i] = DONE;
                     det[i]     = 1'b1;
                  end
               end else begin
                  run_d[i]   = '0;
                  state_d[i] = IDLE;
               end
            end
            DONE: begin
               // stays put on further 1s: a new event needs a 0 first
               if (!bus.in_i[i]) begin
                  run_d[i]   = '0;
                  state_d[i] = IDLE;
               end
            end
            default: begin
               run_d[i]   = '0;
               state_d[i] = IDLE;
            end
         endcase

         // clear opens a new epoch; a detect in the same cycle counts in it
         cnt_cur = bus.clear_i ? '0 : cnt_q[i*CNT_W +: CNT_W];
         if (det[i] && (cnt_cur != {CNT_W{1'b1}}))
            cnt_cur = cnt_cur + CNT_W'(1);
         cnt_d[i*CNT_W +: CNT_W] = cnt_cur;

         if (STICKY != 0)
            match_d[i] = (bus.clear_i ? 1'b0 : match_q[i]) | det[i];
         else
            match_d[i] = (state_d[i] == DONE);
         pulse_d[i] = det[i];
      end
      any_d = |match_d;
   end

   assign bus.match_o       = match_q;
   assign bus.match_pulse_o = pulse_q;
   assign bus.match_count_o = cnt_q;
   assign bus.any_match_o   = any_q;
endmodule
